// File: rtl/ivs_clk_pkg.sv
// Shared types and helpers for the staggered reset / clock-enable sequencer.
package ivs_clk_pkg;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_CNT  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Release delay T_i of channel i, in cycles after the sequencer leaves RST.
    function automatic int rel_dly(input int base, input int step, input int i);
        return base + step * i;
    endfunction

endpackage

// File: rtl/ivs_ce_div.sv
// Per-channel clock-enable divider: one ce pulse every div+1 cycles while released.
module ivs_ce_div #(
    parameter int DIV_W = 8
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic             rel,
    input  logic [DIV_W-1:0] div,
    output logic             ce
);

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] lat_reg;
    logic             ce_reg;

    // rel is the channel's next reset state, so ce drops on the same edge ch_rst_n does.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_reg <= '0;
            lat_reg <= '0;
            ce_reg  <= 1'b0;
        end else if (!rel) begin
            cnt_reg <= '0;
            lat_reg <= div;
            ce_reg  <= 1'b0;
        end else begin
            ce_reg <= (cnt_reg == lat_reg);
            if (cnt_reg == lat_reg) begin
                cnt_reg <= '0;
                lat_reg <= div;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign ce = ce_reg;

endmodule

// File: rtl/ivs_rst_seq.sv
// Staggered per-domain reset sequencer with software channel resets and
// per-channel divided clock enables.
module ivs_rst_seq
    import ivs_clk_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int BASE_DLY    = 32,
    parameter int STEP_DLY    = 8,
    parameter int DIV_W       = 8,
    parameter int SW_RST_CYC  = 16
) (
    input  logic                    aclk,
    input  logic                    arst_n,
    input  logic [NUM_CH-1:0]       sw_rst_req,
    input  logic [NUM_CH*DIV_W-1:0] ch_div,
    output logic [NUM_CH-1:0]       ch_rst_n,
    output logic [NUM_CH-1:0]       ch_ce,
    output logic                    seq_done,
    output logic                    busy
);

    localparam int T_LAST = rel_dly(BASE_DLY, STEP_DLY, NUM_CH - 1);
    localparam logic [CNT_W-1:0] T_LAST_C = CNT_W'(T_LAST);
    localparam logic [CNT_W-1:0] SW_CYC_C = CNT_W'(SW_RST_CYC);

    if (longint'(T_LAST) >= (64'd1 << CNT_W) || longint'(SW_RST_CYC) >= (64'd1 << CNT_W)
        || NUM_CH < 1 || NUM_CH > 16 || SYNC_STAGES < 2) begin : g_param_err
        $error("ivs_rst_seq: parameter set out of range");
    end

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rst_sync_n;
    seq_state_e             state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   seq_done_reg;
    logic                   busy_reg;
    logic [NUM_CH-1:0]      ch_rst_n_reg;
    logic [NUM_CH-1:0]      por_rel;
    logic [NUM_CH-1:0]      sw_act_next;
    logic [NUM_CH-1:0]      rel_next;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= ST_RST;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_RST: begin
                    if (rst_sync_n) begin
                        state_reg <= ST_CNT;
                    end
                end
                ST_CNT: begin
                    if (cnt_reg == T_LAST_C) begin
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_DONE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] sw_cnt_reg;
        logic [CNT_W-1:0] sw_cnt_next;
        logic             sw_act_reg;
        logic             act_next;

        // Gated on ST_RST so a zero delay still releases one edge after the sequencer starts.
        assign por_rel[gi] = (state_reg != ST_RST) && (cnt_reg >= CNT_W'(rel_dly(BASE_DLY, STEP_DLY, gi)));

        // A request on the expiry edge reloads, so the channel stays in reset.
        always_comb begin
            act_next    = sw_act_reg;
            sw_cnt_next = sw_cnt_reg;
            if (sw_rst_req[gi] && seq_done_reg) begin
                act_next    = 1'b1;
                sw_cnt_next = SW_CYC_C;
            end else if (sw_act_reg) begin
                if (sw_cnt_reg <= CNT_W'(1)) begin
                    act_next    = 1'b0;
                    sw_cnt_next = '0;
                end else begin
                    sw_cnt_next = sw_cnt_reg - 1'b1;
                end
            end
        end

        always_ff @(posedge aclk or negedge arst_n) begin
            if (!arst_n) begin
                sw_act_reg <= 1'b0;
                sw_cnt_reg <= '0;
            end else begin
                sw_act_reg <= act_next;
                sw_cnt_reg <= sw_cnt_next;
            end
        end

        assign sw_act_next[gi] = act_next;
        assign rel_next[gi]    = por_rel[gi] && !act_next;

        ivs_ce_div #(
            .DIV_W (DIV_W)
        ) u_ce_div (
            .aclk   (aclk),
            .arst_n (arst_n),
            .rel    (rel_next[gi]),
            .div    (ch_div[gi*DIV_W +: DIV_W]),
            .ce     (ch_ce[gi])
        );
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            ch_rst_n_reg <= '0;
            seq_done_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            ch_rst_n_reg <= rel_next;
            seq_done_reg <= seq_done_reg | por_rel[NUM_CH-1];
            busy_reg     <= |sw_act_next;
        end
    end

    assign ch_rst_n = ch_rst_n_reg;
    assign seq_done = seq_done_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_ivs_rst_seq.sv
// Directed plus randomized bench for ivs_rst_seq, checked every cycle against an
// event-schedule model (release edges, software-reset windows, pulse times).
module tb_ivs_rst_seq;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int BASE_DLY    = 32;
    localparam int STEP_DLY    = 8;
    localparam int DIV_W       = 8;
    localparam int SW_RST_CYC  = 16;

    logic                    aclk = 1'b0;
    logic                    arst_n;
    logic [NUM_CH-1:0]       sw_rst_req;
    logic [NUM_CH*DIV_W-1:0] ch_div;
    logic [NUM_CH-1:0]       ch_rst_n;
    logic [NUM_CH-1:0]       ch_ce;
    logic                    seq_done;
    logic                    busy;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n;
    int sw_end[NUM_CH];
    int next_pulse[NUM_CH];
    logic [NUM_CH-1:0] exp_rst;
    logic [NUM_CH-1:0] exp_ce;
    logic              exp_done;
    logic              exp_busy;

    ivs_rst_seq #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .BASE_DLY    (BASE_DLY),
        .STEP_DLY    (STEP_DLY),
        .DIV_W       (DIV_W),
        .SW_RST_CYC  (SW_RST_CYC)
    ) dut (
        .aclk       (aclk),
        .arst_n     (arst_n),
        .sw_rst_req (sw_rst_req),
        .ch_div     (ch_div),
        .ch_rst_n   (ch_rst_n),
        .ch_ce      (ch_ce),
        .seq_done   (seq_done),
        .busy       (busy)
    );

    always #5 aclk = ~aclk;

    // Edge number (counted from arst_n release) on which channel i leaves power-on reset.
    function automatic int por_edge(input int i);
        return SYNC_STAGES + BASE_DLY + STEP_DLY * i + 2;
    endfunction

    function automatic int div_of(input int i);
        return int'(ch_div[i*DIV_W +: DIV_W]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic check_all();
        chk("ch_rst_n", 32'(ch_rst_n), 32'(exp_rst));
        chk("ch_ce",    32'(ch_ce),    32'(exp_ce));
        chk("seq_done", 32'(seq_done), 32'(exp_done));
        chk("busy",     32'(busy),     32'(exp_busy));
    endtask

    task automatic model_reset();
        edge_n   = 0;
        exp_rst  = '0;
        exp_ce   = '0;
        exp_done = 1'b0;
        exp_busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            sw_end[i]     = 0;
            next_pulse[i] = 0;
        end
    endtask

    // One clock: update the model with the inputs seen at the edge, check half a cycle later.
    task automatic step();
        logic done_before;
        int   d;
        @(posedge aclk);
        if (arst_n) begin
            edge_n++;
            done_before = (edge_n - 1) >= por_edge(NUM_CH - 1);
            exp_busy = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                d = div_of(i);
                if (sw_rst_req[i] && done_before) sw_end[i] = edge_n + SW_RST_CYC;
                exp_rst[i] = (edge_n >= por_edge(i)) && (edge_n >= sw_end[i]);
                if (edge_n < sw_end[i]) exp_busy = 1'b1;
                if (!exp_rst[i]) begin
                    exp_ce[i]     = 1'b0;
                    next_pulse[i] = edge_n + 1 + d;
                end else begin
                    exp_ce[i] = (edge_n == next_pulse[i]);
                    if (exp_ce[i]) next_pulse[i] = edge_n + d + 1;
                end
            end
            exp_done = edge_n >= por_edge(NUM_CH - 1);
        end else begin
            model_reset();
        end
        @(negedge aclk);
        check_all();
        sw_rst_req = '0;
    endtask

    task automatic assert_reset();
        arst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        $display("arst_n asserted at time %0t", $time);
    endtask

    task automatic sw_req(input int ch);
        sw_rst_req[ch] = 1'b1;
        $display("sw_rst_req ch%0d before edge %0d", ch, edge_n + 1);
    endtask

    initial begin
        arst_n     = 1'b0;
        sw_rst_req = '0;
        ch_div     = {8'd5, 8'd2, 8'd3, 8'd0};
        model_reset();
        repeat (3) step();

        // Power-on sequence, with a request during CNT that must be ignored.
        arst_n = 1'b1;
        $display("arst_n released, power-on sequence");
        repeat (30) step();
        sw_req(1);
        step();
        repeat (40) step();

        // Single software reset on channel 2.
        sw_req(2);
        step();
        repeat (25) step();

        // Extended software reset: second request five cycles later.
        sw_req(2);
        step();
        repeat (4) step();
        sw_req(2);
        step();
        repeat (25) step();

        // Divide change 3 -> 1 on channel 1 mid-period.
        repeat (2) step();
        ch_div[DIV_W +: DIV_W] = 8'd1;
        $display("ch_div[1] changed to 1 at edge %0d", edge_n);
        repeat (15) step();

        // Asynchronous reset after done, then again 45 cycles into the sequence.
        assert_reset();
        repeat (2) step();
        arst_n = 1'b1;
        repeat (45) step();
        assert_reset();
        repeat (3) step();
        arst_n = 1'b1;
        repeat (70) step();

        // Randomized requests, divide changes and occasional asynchronous resets.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 29) == 0) sw_req(int'($urandom_range(0, NUM_CH - 1)));
            if ($urandom_range(0, 99) == 0) begin
                ch_div[$urandom_range(0, NUM_CH - 1)*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 6));
                $display("ch_div now %0h at edge %0d", ch_div, edge_n);
            end
            if ($urandom_range(0, 499) == 0) begin
                assert_reset();
                repeat (2) step();
                arst_n = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
